// File: rtl/ped_crossing_ctrl_pkg.sv
// Shared definitions for the pedestrian-crossing stage: vehicle light codes
// and the crossing controller state encoding.
package ped_crossing_ctrl_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  function automatic logic light_legal(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_GREEN) || (code == LIGHT_YELLOW);
  endfunction

endpackage

// File: rtl/ped_crossing_ctrl_btn_debounce.sv
// Push-button synchronizer and tick-based debouncer; press pulses once per
// stable press, on the tick that brings the counter to DEBOUNCE_TICKS.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic press
);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (!sync2)
        cnt <= '0;
      else if (tick && (cnt < 4'(DEBOUNCE_TICKS)))
        cnt <= cnt + 4'd1;
    end
  end

  // Counter saturates at DEBOUNCE_TICKS, so this fires once per press.
  assign press = sync2 && tick && (cnt == 4'(DEBOUNCE_TICKS - 1));

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing controller: grants WALK at the start of a vehicle RED
// phase, then a flashing DON'T WALK countdown; aborts or faults on bad lights.
module ped_crossing_ctrl
  import ped_crossing_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 3,
  parameter int unsigned WALK_TICKS     = 5,
  parameter int unsigned FLASH_TICKS    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic [7:0] countdown,
  output logic       abort,
  output logic       fault
);

  state_t     state;
  logic [2:0] light_q;
  logic [7:0] timer;
  logic       press;
  logic       red_start;

  btn_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .btn  (ped_btn),
    .press(press)
  );

  assign red_start = (light == LIGHT_RED) && (light_q != LIGHT_RED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      light_q     <= LIGHT_RED;
      timer       <= '0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      countdown   <= '0;
      abort       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      light_q <= light;
      abort   <= 1'b0;
      if (!light_legal(light)) begin
        state       <= ST_FAULT;
        walk        <= 1'b0;
        dont_walk   <= 1'b1;
        countdown   <= '0;
        req_pending <= 1'b0;
        fault       <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            // A press coinciding with red_start only latches; it cannot be granted this RED.
            if (req_pending && red_start) begin
              state       <= ST_WALK;
              req_pending <= 1'b0;
              timer       <= 8'(WALK_TICKS);
              walk        <= 1'b1;
              dont_walk   <= 1'b0;
            end else if (press) begin
              req_pending <= 1'b1;
            end
          end
          ST_WALK, ST_FLASH: begin
            if (light != LIGHT_RED) begin
              state     <= ST_IDLE;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              countdown <= '0;
              abort     <= 1'b1;
            end else if (tick) begin
              if (timer == 8'd1) begin
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                if (state == ST_WALK) begin
                  state     <= ST_FLASH;
                  timer     <= 8'(FLASH_TICKS);
                  countdown <= 8'(FLASH_TICKS);
                end else begin
                  state     <= ST_IDLE;
                  countdown <= '0;
                end
              end else begin
                timer <= timer - 8'd1;
                if (state == ST_FLASH) begin
                  countdown <= timer - 8'd1;
                  dont_walk <= ~dont_walk;
                end
              end
            end
          end
          default: begin
            state     <= ST_FAULT;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= '0;
            fault     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with hand-computed expectations.
module tb_ped_crossing_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [2:0] light;
  logic       ped_btn;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic [7:0] countdown;
  logic       abort;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b100;

  ped_crossing_ctrl #(
    .DEBOUNCE_TICKS(3),
    .WALK_TICKS    (5),
    .FLASH_TICKS   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .light      (light),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .countdown  (countdown),
    .abort      (abort),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given tick value; outputs sampled 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic outs(input string tag, input logic w, input logic dw, input logic rp,
                      input logic [7:0] cd, input logic ab, input logic fl);
    check({tag, ".walk"}, {7'd0, walk}, {7'd0, w});
    check({tag, ".dont_walk"}, {7'd0, dont_walk}, {7'd0, dw});
    check({tag, ".req_pending"}, {7'd0, req_pending}, {7'd0, rp});
    check({tag, ".countdown"}, countdown, cd);
    check({tag, ".abort"}, {7'd0, abort}, {7'd0, ab});
    check({tag, ".fault"}, {7'd0, fault}, {7'd0, fl});
  endtask

  // Raises the button and lets it through the synchronizer, then gives n ticks.
  task automatic press_ticks(input int n);
    ped_btn = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  task automatic release_btn();
    ped_btn = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; light = RED; ped_btn = 1'b0;
    #12;
    outs("reset", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    light = GREEN;
    cyc(1'b0);

    // Two-tick glitch is not a press.
    press_ticks(2);
    release_btn();
    check("glitch.req", {7'd0, req_pending}, 8'd0);

    // Full press: pending after exactly the third tick.
    press_ticks(2);
    check("press2.req", {7'd0, req_pending}, 8'd0);
    cyc(1'b1);
    check("press3.req", {7'd0, req_pending}, 8'd1);
    release_btn();

    // Yellow -> red start grants WALK one clk later.
    light = YELLOW; cyc(1'b0);
    check("yellow.walk", {7'd0, walk}, 8'd0);
    light = RED; cyc(1'b0);
    outs("walk0", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1);
    check("walk4.walk", {7'd0, walk}, 8'd1);
    cyc(1'b1);
    outs("flash4", 1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0);
    cyc(1'b0);
    check("flash_notick.cd", countdown, 8'd4);
    cyc(1'b1); outs("flash3", 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
    cyc(1'b1); outs("flash2", 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
    cyc(1'b1); outs("flash1", 1'b0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
    cyc(1'b1); outs("flash_end", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

    // Press accepted mid-RED waits for the next red start.
    press_ticks(3);
    release_btn();
    for (int i = 0; i < 3; i++) cyc(1'b1);
    check("midred.walk", {7'd0, walk}, 8'd0);
    check("midred.req", {7'd0, req_pending}, 8'd1);
    light = GREEN; cyc(1'b0);
    check("midred_green.walk", {7'd0, walk}, 8'd0);
    light = RED; cyc(1'b0);
    check("midred_next.walk", {7'd0, walk}, 8'd1);

    // Light released on the third WALK tick: abort beats the tick.
    cyc(1'b1); cyc(1'b1);
    light = GREEN; cyc(1'b1);
    outs("abort", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
    cyc(1'b0);
    check("abort_pulse_end", {7'd0, abort}, 8'd0);
    check("abort_idle.walk", {7'd0, walk}, 8'd0);

    // Press and red start on the same edge: latched, not granted.
    press_ticks(2);
    light = RED; cyc(1'b1);
    check("simul.walk", {7'd0, walk}, 8'd0);
    check("simul.req", {7'd0, req_pending}, 8'd1);
    release_btn();
    check("simul_wait.walk", {7'd0, walk}, 8'd0);
    light = YELLOW; cyc(1'b0);
    light = RED; cyc(1'b0);
    check("simul_next.walk", {7'd0, walk}, 8'd1);
    light = YELLOW; cyc(1'b0);
    check("abort2.abort", {7'd0, abort}, 8'd1);

    // Illegal light code latches fault; later activity ignored.
    light = 3'b011; cyc(1'b0);
    outs("fault", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
    light = GREEN;
    press_ticks(3);
    release_btn();
    light = RED; cyc(1'b0);
    cyc(1'b1);
    outs("fault_hold", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1);

    // Clear fault, reach FLASH, then assert reset asynchronously.
    rst = 1'b1; #1;
    check("rst_clear.fault", {7'd0, fault}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    light = GREEN; cyc(1'b0);
    press_ticks(3);
    release_btn();
    light = RED; cyc(1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1);
    outs("pre_rst_flash", 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    outs("async_rst", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
